// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the program-counter / fetch unit.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUN,
        HALT
    } fetch_state_t;

    localparam int PC_W       = 10;
    localparam int START_ADDR = 0;
    localparam int LUT_IDX_W  = 5;

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// Absolute branch target table: 5-bit index to PC_W-bit target.
module branch_lut #(
    parameter int PC_W = 10
) (
    input  logic [4:0]      index,
    output logic [PC_W-1:0] target
);

    always_comb begin
        target = '0;
        case (index)
            5'd0:  target = PC_W'(10'd0);
            5'd1:  target = PC_W'(10'd32);
            5'd2:  target = PC_W'(10'd64);
            5'd3:  target = PC_W'(10'd96);
            5'd4:  target = PC_W'(10'd128);
            5'd5:  target = PC_W'(10'd160);
            5'd6:  target = PC_W'(10'd192);
            5'd7:  target = PC_W'(10'd224);
            5'd8:  target = PC_W'(10'd256);
            5'd9:  target = PC_W'(10'd288);
            5'd10: target = PC_W'(10'd320);
            5'd11: target = PC_W'(10'd352);
            5'd12: target = PC_W'(10'd384);
            5'd13: target = PC_W'(10'd416);
            5'd14: target = PC_W'(10'd448);
            5'd15: target = PC_W'(10'd480);
            5'd16: target = PC_W'(10'd512);
            5'd17: target = PC_W'(10'd544);
            5'd18: target = PC_W'(10'd576);
            5'd19: target = PC_W'(10'd608);
            5'd20: target = PC_W'(10'd640);
            5'd21: target = PC_W'(10'd672);
            5'd22: target = PC_W'(10'd704);
            5'd23: target = PC_W'(10'd736);
            5'd24: target = PC_W'(10'd768);
            5'd25: target = PC_W'(10'd800);
            5'd26: target = PC_W'(10'd832);
            5'd27: target = PC_W'(10'd864);
            5'd28: target = PC_W'(10'd896);
            5'd29: target = PC_W'(10'd928);
            5'd30: target = PC_W'(10'd960);
            5'd31: target = PC_W'(10'd992);
            default: target = '0;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// PC / fetch sequencer with LUT and relative branches.
// Optional RUN-cycle counter enabled by defining CYCLE_COUNT_EN.
module fetch_unit #(
    parameter int PC_W       = 10,
    parameter int START_ADDR = 0,
    parameter int CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             BranchAbs,
    input  logic             BaddEn,
    input  logic             BsubEn,
    input  logic             BranchTaken,
    input  logic             Ack,
    input  logic [PC_W-1:0]  PCTarg,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Done,
    output logic [CNT_W-1:0] CycleCount
);

    import fetch_unit_pkg::*;

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    fetch_state_t    state;
    logic [PC_W-1:0] lut_targ;
    logic [PC_W-1:0] off;
    logic            unused_targ;

    assign off = {{(PC_W-LUT_IDX_W){1'b0}}, PCTarg[LUT_IDX_W-1:0]};
    assign unused_targ = ^PCTarg[PC_W-1:LUT_IDX_W];

    branch_lut #(.PC_W(PC_W)) u_lut (
        .index  (PCTarg[LUT_IDX_W-1:0]),
        .target (lut_targ)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= IDLE;
            ProgCtr <= '0;
            Done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        ProgCtr <= START_PC;
                        state   <= ARMED;
                    end
                end
                ARMED: begin
                    if (Start) ProgCtr <= START_PC;
                    else       state   <= RUN;
                end
                RUN: begin
                    if (Start) begin
                        ProgCtr <= START_PC;
                        state   <= ARMED;
                    end else if (Ack) begin
                        Done  <= 1'b1;
                        state <= HALT;
                    end else if (BranchAbs) begin
                        ProgCtr <= lut_targ;
                    end else if (BaddEn && BranchTaken) begin
                        ProgCtr <= ProgCtr + off;
                    end else if (BsubEn && BranchTaken) begin
                        ProgCtr <= ProgCtr - off;
                    end else begin
                        ProgCtr <= ProgCtr + 1'b1;
                    end
                end
                HALT: begin
                    if (Start) begin
                        Done    <= 1'b0;
                        ProgCtr <= START_PC;
                        state   <= ARMED;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CYCLE_COUNT_EN
    // Start from any state lands in ARMED, which restarts the count.
    always_ff @(posedge Clk) begin
        if (Reset || Start)
            CycleCount <= '0;
        else if (state == RUN && !Ack && CycleCount != '1)
            CycleCount <= CycleCount + 1'b1;
    end
`else
    assign CycleCount = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed checks for fetch_unit.
module tb_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset, Start, BranchAbs, BaddEn, BsubEn;
    logic        BranchTaken, Ack;
    logic [9:0]  PCTarg;
    logic [9:0]  ProgCtr;
    logic        Done;
    logic [15:0] CycleCount;

    int total = 0;
    int bad   = 0;

    fetch_unit dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .BranchAbs   (BranchAbs),
        .BaddEn      (BaddEn),
        .BsubEn      (BsubEn),
        .BranchTaken (BranchTaken),
        .Ack         (Ack),
        .PCTarg      (PCTarg),
        .ProgCtr     (ProgCtr),
        .Done        (Done),
        .CycleCount  (CycleCount)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        Start = 0; BranchAbs = 0; BaddEn = 0; BsubEn = 0;
        BranchTaken = 0; Ack = 0; PCTarg = '0; Reset = 0;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Reach target PC via LUT entry (tgt/32) then a taken forward offset.
    task automatic jump_to(input int tgt);
        clr();
        BranchAbs = 1;
        PCTarg = 10'(tgt / 32);
        step();
        clr();
        if (tgt % 32 != 0) begin
            BaddEn = 1; BranchTaken = 1;
            PCTarg = 10'(tgt % 32);
            step();
            clr();
        end
        chk("jump", int'(ProgCtr), tgt);
    endtask

    int exp_cnt;

    initial begin
        clr();
        Reset = 1;
        step();
        chk("rst_pc", int'(ProgCtr), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_cnt", int'(CycleCount), 0);

        // 1: start sequence
        clr(); Start = 1; step();
        chk("s1_pc0", int'(ProgCtr), 0);
        step();
        chk("s1_pc1", int'(ProgCtr), 0);
        Start = 0; step();
        chk("s1_pc2", int'(ProgCtr), 0);
        step(); chk("s1_pc3", int'(ProgCtr), 1);
        step(); chk("s1_pc4", int'(ProgCtr), 2);
        step(); chk("s1_pc5", int'(ProgCtr), 3);
        chk("s1_done", int'(Done), 0);

        // 2: absolute branch
        step(); step();
        chk("s2_pc5", int'(ProgCtr), 5);
        BranchAbs = 1; PCTarg = 10'd3; step(); clr();
        chk("s2_abs", int'(ProgCtr), 96);
        step();
        chk("s2_inc", int'(ProgCtr), 97);

        // 3: relative branches
        jump_to(20);
        BaddEn = 1; BranchTaken = 1; PCTarg = 10'd7; step(); clr();
        chk("s3_add", int'(ProgCtr), 27);
        jump_to(20);
        BaddEn = 1; BranchTaken = 0; PCTarg = 10'd7; step(); clr();
        chk("s3_nt", int'(ProgCtr), 21);
        jump_to(20);
        BsubEn = 1; BranchTaken = 1; PCTarg = 10'd4; step(); clr();
        chk("s3_sub", int'(ProgCtr), 16);
        BsubEn = 1; BranchTaken = 0; PCTarg = 10'd4; step(); clr();
        chk("s3_subnt", int'(ProgCtr), 17);

        // 4: wrap and spin
        jump_to(1022);
        BaddEn = 1; BranchTaken = 1; PCTarg = 10'd5; step(); clr();
        chk("s4_wrapadd", int'(ProgCtr), 3);
        jump_to(2);
        BsubEn = 1; BranchTaken = 1; PCTarg = 10'd5; step(); clr();
        chk("s4_wrapsub", int'(ProgCtr), 1021);
        jump_to(1023);
        step();
        chk("s4_wrapinc", int'(ProgCtr), 0);
        jump_to(50);
        BaddEn = 1; BranchTaken = 1; PCTarg = 10'd0; step();
        chk("s4_spin0", int'(ProgCtr), 50);
        step(); clr();
        chk("s4_spin1", int'(ProgCtr), 50);
        PCTarg = 10'h3E3; BranchAbs = 1; step(); clr();
        chk("s4_hibits", int'(ProgCtr), 96);

        // 5: halt
        jump_to(40);
        Ack = 1; BranchAbs = 1; PCTarg = 10'd3; step(); clr();
        chk("s5_pc", int'(ProgCtr), 40);
        chk("s5_done", int'(Done), 1);
        Ack = 1; BaddEn = 1; BranchTaken = 1; PCTarg = 10'd9;
        step(); clr();
        chk("s5_hold", int'(ProgCtr), 40);
        chk("s5_done2", int'(Done), 1);
        Start = 1; step();
        chk("s5_rs_done", int'(Done), 0);
        chk("s5_rs_pc", int'(ProgCtr), 0);
        Start = 0; step();
        step();
        chk("s5_run", int'(ProgCtr), 1);

        // 6: reset mid-run, then inputs ignored in IDLE
        jump_to(77);
        Reset = 1; step(); clr();
        chk("s6_pc", int'(ProgCtr), 0);
        chk("s6_done", int'(Done), 0);
        BranchAbs = 1; PCTarg = 10'd3; step();
        Ack = 1; step(); clr();
        chk("s6_idle", int'(ProgCtr), 0);
        chk("s6_idle_d", int'(Done), 0);

        // cycle counter: 10 RUN cycles then Ack
        Start = 1; step();
        Start = 0; step();
        chk("cnt_start", int'(CycleCount), 0);
        repeat (10) step();
        chk("cnt_pc", int'(ProgCtr), 10);
        Ack = 1; step(); clr();
`ifdef CYCLE_COUNT_EN
        exp_cnt = 10;
`else
        exp_cnt = 0;
`endif
        chk("cnt_halt", int'(CycleCount), exp_cnt);
        step(); step();
        chk("cnt_hold", int'(CycleCount), exp_cnt);
        chk("cnt_done", int'(Done), 1);
        Start = 1; step(); clr();
        chk("cnt_clr", int'(CycleCount), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
